// File: rtl/debug_led_viewer.sv
// Board-level debug viewer: shows one LED_W-bit slice of a probe bank (or the
// status flags) on the LEDs, with manual select, timed auto-scan and freeze.
module debug_led_viewer #(
   parameter  int NUM_WORDS = 2,
   parameter  int WORD_W    = 32,
   parameter  int LED_W     = 8,
   parameter  int SCAN_DIV  = 50_000_000,
   localparam int SPW       = WORD_W / LED_W,
   localparam int NSLICE    = NUM_WORDS * SPW,
   localparam int FLAG_IDX  = NSLICE,
   localparam int SEL_W     = $clog2(NSLICE + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_WORDS*WORD_W-1:0] probe_bus,
   input  logic [1:0]                  flags,
   input  logic [SEL_W-1:0]            sel,
   input  logic                        auto_en,
   input  logic                        freeze_pulse,
   output logic [LED_W-1:0]            led,
   output logic [SEL_W-1:0]            cur_idx,
   output logic                        frozen
);

   localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int               IDX_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [SEL_W-1:0] FLAG_SEL = SEL_W'(FLAG_IDX);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   if ((WORD_W % LED_W) != 0 || LED_W < 2 || SCAN_DIV < 1) begin : g_bad_params
      $error("debug_led_viewer: illegal parameter combination");
   end

   logic [DIV_W-1:0]              r_div;
   logic [SEL_W-1:0]              r_cur_idx;
   logic [LED_W-1:0]              r_led;
   logic                          r_frozen;
   logic [NUM_WORDS*WORD_W-1:0]   r_snap_bus;
   logic [1:0]                    r_snap_flags;

   logic [NUM_WORDS*WORD_W-1:0]   w_src_bus;
   logic [1:0]                    w_src_flags;
   logic [NSLICE-1:0][LED_W-1:0]  w_slices;
   logic [IDX_W-1:0]              w_slice_sel;
   logic [SEL_W-1:0]              w_step_idx;
   logic [LED_W-1:0]              w_led_next;

   // Slice i of the concatenated bus is word i/SPW, byte i%SPW, because word 0 sits in the LSBs.
   assign w_src_bus   = r_frozen ? r_snap_bus   : probe_bus;
   assign w_src_flags = r_frozen ? r_snap_flags : flags;
   assign w_slices    = w_src_bus;
   assign w_slice_sel = r_cur_idx[IDX_W-1:0];
   assign w_step_idx  = (r_cur_idx < FLAG_SEL) ? r_cur_idx + SEL_W'(1) : '0;

   always_comb begin
      // NOTE: default first so every bit is driven on every path; no latch can be inferred.
      w_led_next = '0;
      if (r_cur_idx < FLAG_SEL) begin
         w_led_next = w_slices[w_slice_sel];
      end else if (r_cur_idx == FLAG_SEL) begin
         w_led_next[0]       = w_src_flags[0];
         w_led_next[LED_W-1] = w_src_flags[1];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div     <= '0;
         r_cur_idx <= '0;
      end else if (!auto_en) begin
         r_div     <= '0;
         r_cur_idx <= sel;
      end else if (r_div == DIV_LAST) begin
         r_div     <= '0;
         r_cur_idx <= w_step_idx;
      end else begin
         r_div     <= r_div + DIV_W'(1);
      end
   end

   // Snapshot is captured only on the edge that enters freeze, so it equals the live data led shows next.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frozen     <= 1'b0;
         r_snap_bus   <= '0;
         r_snap_flags <= '0;
      end else if (freeze_pulse) begin
         r_frozen <= ~r_frozen;
         if (!r_frozen) begin
            r_snap_bus   <= probe_bus;
            r_snap_flags <= flags;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_led <= '0;
      else     r_led <= w_led_next;
   end

   assign led     = r_led;
   assign cur_idx = r_cur_idx;
   assign frozen  = r_frozen;

endmodule
